// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types and helpers for the load-use hazard stall controller.
//   state_e   : FSM state encoding (IDLE, STALL)
//   rem_width : width of the remaining-stall down-counter for a load latency
// -----------------------------------------------------------------------------
package hazard_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_e;

    // Bits needed to hold the values 0..lat; a minimum of 1 keeps the
    // counter legal even for degenerate latencies.
    function automatic int rem_width(input int lat);
        if (lat < 1) begin
            return 1;
        end else begin
            return $clog2(lat + 1);
        end
    endfunction

endpackage : hazard_pkg

// File: rtl/hazard_src_match.sv
// -----------------------------------------------------------------------------
// hazard_src_match
// Compares one source-register read port of the IF/ID instruction against the
// destination register of the load in ID/EX.
//   src_addr_i : source register address
//   src_used_i : source is actually read by the instruction
//   dst_addr_i : load destination register address
//   match_o    : source depends on the load result
// -----------------------------------------------------------------------------
module hazard_src_match #(
    parameter int ADDR_W      = 5,
    parameter bit ZERO_REG_EN = 1'b1
) (
    input  logic [ADDR_W-1:0] src_addr_i,
    input  logic              src_used_i,
    input  logic [ADDR_W-1:0] dst_addr_i,
    output logic              match_o
);

    logic is_zero_s;

    // Register 0 is hardwired, so it can never carry a real dependency.
    assign is_zero_s = ZERO_REG_EN && (src_addr_i == {ADDR_W{1'b0}});

    // Per-source dependency detection.
    assign match_o = src_used_i && (src_addr_i == dst_addr_i) && !is_zero_s;

endmodule : hazard_src_match

// File: rtl/hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl
// Load-use hazard controller for the ID stage. Detects a dependency of the
// IF/ID instruction on a load in ID/EX and stalls PC/IF-ID while injecting
// bubbles into ID/EX for LOAD_LAT cycles. A flush aborts any stall.
//   clk_i           : pipeline clock
//   rst_i           : asynchronous active-low reset
//   ID_EX_MemRead_i : ID/EX instruction is a load
//   ID_EX_RdAddr_i  : load destination register
//   IF_ID_SrcAddr_i : packed source addresses, source k at [k*ADDR_W +: ADDR_W]
//   IF_ID_SrcUsed_i : per-source "actually read" flags
//   flush_i         : taken branch/jump discards IF/ID this cycle
//   stall_o         : hazard stall active
//   pc_write_o      : PC update enable
//   if_id_write_o   : IF/ID update enable
//   id_ex_bubble_o  : zero the ID/EX control fields
//   stall_cnt_o     : saturating count of stalled cycles
// -----------------------------------------------------------------------------
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int ADDR_W      = 5,
    parameter int NUM_SRC     = 2,
    parameter int LOAD_LAT    = 1,
    parameter int ZERO_REG_EN = 1,
    parameter int CNT_W       = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      ID_EX_MemRead_i,
    input  logic [ADDR_W-1:0]         ID_EX_RdAddr_i,
    input  logic [NUM_SRC*ADDR_W-1:0] IF_ID_SrcAddr_i,
    input  logic [NUM_SRC-1:0]        IF_ID_SrcUsed_i,
    input  logic                      flush_i,
    output logic                      stall_o,
    output logic                      pc_write_o,
    output logic                      if_id_write_o,
    output logic                      id_ex_bubble_o,
    output logic [CNT_W-1:0]          stall_cnt_o
);

    localparam int             REM_W    = rem_width(LOAD_LAT);
    localparam bit             MULTI    = (LOAD_LAT > 1);
    localparam logic [REM_W-1:0] REM_INIT = REM_W'(LOAD_LAT - 1);
    localparam logic [REM_W-1:0] REM_ONE  = REM_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_e             state_q;
    logic [REM_W-1:0]   rem_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [NUM_SRC-1:0] match_s;
    logic               hit_s;
    logic               stall_s;

    // One comparator per source read port.
    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        hazard_src_match #(
            .ADDR_W      (ADDR_W),
            .ZERO_REG_EN (ZERO_REG_EN != 0)
        ) u_match (
            .src_addr_i (IF_ID_SrcAddr_i[k*ADDR_W +: ADDR_W]),
            .src_used_i (IF_ID_SrcUsed_i[k]),
            .dst_addr_i (ID_EX_RdAddr_i),
            .match_o    (match_s[k])
        );
    end

    assign hit_s = ID_EX_MemRead_i && (|match_s);

    // Stall decision: zero-latency on detection, held while draining the
    // load latency; a flush discards the dependent instruction so it wins.
    always_comb begin
        stall_s = 1'b0;
        case (state_q)
            IDLE:    stall_s = hit_s && !flush_i;
            STALL:   stall_s = !flush_i;
            default: stall_s = 1'b0;
        endcase
    end

    // FSM, remaining-stall counter and saturating performance counter.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            rem_q   <= {REM_W{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            if (stall_s && (cnt_q != CNT_MAX)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else begin
                cnt_q <= cnt_q;
            end

            if (flush_i) begin
                state_q <= IDLE;
                rem_q   <= {REM_W{1'b0}};
            end else begin
                case (state_q)
                    IDLE: begin
                        // Single-cycle latency needs no extra state.
                        if (hit_s && MULTI) begin
                            state_q <= STALL;
                            rem_q   <= REM_INIT;
                        end else begin
                            state_q <= IDLE;
                            rem_q   <= {REM_W{1'b0}};
                        end
                    end
                    STALL: begin
                        if (rem_q <= REM_ONE) begin
                            state_q <= IDLE;
                            rem_q   <= {REM_W{1'b0}};
                        end else begin
                            state_q <= STALL;
                            rem_q   <= rem_q - REM_ONE;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        rem_q   <= {REM_W{1'b0}};
                    end
                endcase
            end
        end
    end

    // Reset forces the pipeline-control outputs to their free-running values
    // immediately, without waiting for a clock edge.
    assign stall_o        = rst_i && stall_s;
    assign pc_write_o     = !stall_o;
    assign if_id_write_o  = !stall_o;
    assign id_ex_bubble_o = stall_o;
    assign stall_cnt_o    = cnt_q;

endmodule : hazard_stall_ctrl

// File: tb/tb_hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_stall_ctrl
// Directed bench for hazard_stall_ctrl. Four instances share the stimulus:
//   a : LOAD_LAT=1, b : LOAD_LAT=3, c : LOAD_LAT=4, d : LOAD_LAT=1 CNT_W=4
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

    localparam int AW = 5;

    logic          clk;
    logic          rst;
    logic          memread;
    logic [AW-1:0] rd;
    logic [2*AW-1:0] src;
    logic [1:0]    used;
    logic          flush;

    logic        stall_a, pcw_a, ifw_a, bub_a;
    logic        stall_b, pcw_b, ifw_b, bub_b;
    logic        stall_c, pcw_c, ifw_c, bub_c;
    logic        stall_d, pcw_d, ifw_d, bub_d;
    logic [15:0] cnt_a, cnt_b, cnt_c;
    logic [3:0]  cnt_d;

    int tests;
    int fails;

    hazard_stall_ctrl #(.LOAD_LAT(1)) u_a (
        .clk_i(clk), .rst_i(rst), .ID_EX_MemRead_i(memread), .ID_EX_RdAddr_i(rd),
        .IF_ID_SrcAddr_i(src), .IF_ID_SrcUsed_i(used), .flush_i(flush),
        .stall_o(stall_a), .pc_write_o(pcw_a), .if_id_write_o(ifw_a),
        .id_ex_bubble_o(bub_a), .stall_cnt_o(cnt_a));

    hazard_stall_ctrl #(.LOAD_LAT(3)) u_b (
        .clk_i(clk), .rst_i(rst), .ID_EX_MemRead_i(memread), .ID_EX_RdAddr_i(rd),
        .IF_ID_SrcAddr_i(src), .IF_ID_SrcUsed_i(used), .flush_i(flush),
        .stall_o(stall_b), .pc_write_o(pcw_b), .if_id_write_o(ifw_b),
        .id_ex_bubble_o(bub_b), .stall_cnt_o(cnt_b));

    hazard_stall_ctrl #(.LOAD_LAT(4)) u_c (
        .clk_i(clk), .rst_i(rst), .ID_EX_MemRead_i(memread), .ID_EX_RdAddr_i(rd),
        .IF_ID_SrcAddr_i(src), .IF_ID_SrcUsed_i(used), .flush_i(flush),
        .stall_o(stall_c), .pc_write_o(pcw_c), .if_id_write_o(ifw_c),
        .id_ex_bubble_o(bub_c), .stall_cnt_o(cnt_c));

    hazard_stall_ctrl #(.LOAD_LAT(1), .CNT_W(4)) u_d (
        .clk_i(clk), .rst_i(rst), .ID_EX_MemRead_i(memread), .ID_EX_RdAddr_i(rd),
        .IF_ID_SrcAddr_i(src), .IF_ID_SrcUsed_i(used), .flush_i(flush),
        .stall_o(stall_d), .pc_write_o(pcw_d), .if_id_write_o(ifw_d),
        .id_ex_bubble_o(bub_d), .stall_cnt_o(cnt_d));

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        memread = 1'b0;
        rd      = 5'd0;
        src     = 10'd0;
        used    = 2'b00;
        flush   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b0;
        idle_inputs();

        // Reset gates outputs even with a live hazard on the inputs.
        #2;
        memread = 1'b1; rd = 5'd5; src = {5'd0, 5'd5}; used = 2'b01;
        #1;
        check("rst_stall_a", 32'(stall_a), 32'd0);
        check("rst_pcw_a",   32'(pcw_a),   32'd1);
        check("rst_ifw_b",   32'(ifw_b),   32'd1);
        check("rst_bub_c",   32'(bub_c),   32'd0);
        @(negedge clk);
        #1;
        check("rst_cnt_a", 32'(cnt_a), 32'd0);

        // LOAD_LAT=1: one stall cycle for a hazard on source 0.
        do_reset();
        memread = 1'b1; rd = 5'd5; src = {5'd0, 5'd5}; used = 2'b01;
        #1;
        check("l1_stall",  32'(stall_a), 32'd1);
        check("l1_bubble", 32'(bub_a),   32'd1);
        check("l1_pcw",    32'(pcw_a),   32'd0);
        check("l1_ifw",    32'(ifw_a),   32'd0);
        @(negedge clk);
        memread = 1'b0;
        #1;
        check("l1_release", 32'(stall_a), 32'd0);
        check("l1_pcw_back", 32'(pcw_a),  32'd1);
        check("l1_cnt",     32'(cnt_a),   32'd1);

        // LOAD_LAT=3: hazard on source 1 stalls three consecutive cycles.
        do_reset();
        memread = 1'b1; rd = 5'd5; src = {5'd5, 5'd0}; used = 2'b10;
        #1;
        check("l3_c1_stall", 32'(stall_b), 32'd1);
        check("l3_c1_pcw",   32'(pcw_b),   32'd0);
        @(negedge clk);
        memread = 1'b0;
        #1;
        check("l3_c2_stall", 32'(stall_b), 32'd1);
        check("l3_c2_pcw",   32'(pcw_b),   32'd0);
        @(negedge clk);
        #1;
        check("l3_c3_stall", 32'(stall_b), 32'd1);
        check("l3_c3_pcw",   32'(pcw_b),   32'd0);
        @(negedge clk);
        #1;
        check("l3_c4_stall", 32'(stall_b), 32'd0);
        check("l3_c4_pcw",   32'(pcw_b),   32'd1);
        check("l3_cnt",      32'(cnt_b),   32'd3);

        // No-hazard patterns.
        do_reset();
        memread = 1'b1; rd = 5'd0; src = {5'd0, 5'd0}; used = 2'b11;
        #1;
        check("nh_zero_b", 32'(stall_b), 32'd0);
        check("nh_zero_a", 32'(stall_a), 32'd0);
        @(negedge clk);
        memread = 1'b1; rd = 5'd7; src = {5'd3, 5'd7}; used = 2'b10;
        #1;
        check("nh_unused_b", 32'(stall_b), 32'd0);
        check("nh_unused_c", 32'(stall_c), 32'd0);
        @(negedge clk);
        memread = 1'b0; rd = 5'd5; src = {5'd5, 5'd5}; used = 2'b11;
        #1;
        check("nh_noload_b", 32'(stall_b), 32'd0);
        check("nh_noload_a", 32'(stall_a), 32'd0);
        @(negedge clk);
        #1;
        check("nh_cnt_b", 32'(cnt_b), 32'd0);

        // LOAD_LAT=4: flush in the second stall cycle aborts the stall.
        do_reset();
        memread = 1'b1; rd = 5'd9; src = {5'd0, 5'd9}; used = 2'b01;
        #1;
        check("fl_c1_stall", 32'(stall_c), 32'd1);
        @(negedge clk);
        memread = 1'b0; flush = 1'b1;
        #1;
        check("fl_c2_stall", 32'(stall_c), 32'd0);
        check("fl_c2_pcw",   32'(pcw_c),   32'd1);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("fl_c3_stall", 32'(stall_c), 32'd0);
        check("fl_cnt",      32'(cnt_c),   32'd1);
        @(negedge clk);
        #1;
        check("fl_c4_stall", 32'(stall_c), 32'd0);
        check("fl_cnt_hold", 32'(cnt_c),   32'd1);

        // LOAD_LAT=3: asynchronous reset in the second stall cycle.
        do_reset();
        memread = 1'b1; rd = 5'd5; src = {5'd0, 5'd5}; used = 2'b01;
        @(negedge clk);
        memread = 1'b0;
        #1;
        check("ar_c2_stall", 32'(stall_b), 32'd1);
        rst = 1'b0;
        #1;
        check("ar_stall", 32'(stall_b), 32'd0);
        check("ar_pcw",   32'(pcw_b),   32'd1);
        check("ar_cnt",   32'(cnt_b),   32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("ar_post1", 32'(stall_b), 32'd0);
        @(negedge clk);
        #1;
        check("ar_post2", 32'(stall_b), 32'd0);
        check("ar_post_cnt", 32'(cnt_b), 32'd0);

        // CNT_W=4: counter saturates at 15 under a continuously held hazard.
        do_reset();
        memread = 1'b1; rd = 5'd4; src = {5'd4, 5'd0}; used = 2'b10;
        for (int i = 1; i <= 22; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("sat_%0d", i), 32'(cnt_d), (i > 15) ? 32'd15 : 32'(i));
        end
        idle_inputs();

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_hazard_stall_ctrl
